mujica_key_conditioner: RTL and testbench
=========================================

Name: mujica_key_conditioner

Overview:
- Upstream stage of the Mujica top control FSM.
- Conditions four raw mechanical pushbuttons: power, save, fetch and finish.
- For each button it provides a two-flop synchroniser, a debounce state machine and press-edge detection, so the control FSM sees clean one-cycle command pulses in the sys_clk domain.
- Start commands are mutually exclusive: when presses coincide, power wins over save, and save wins over fetch.

Parameters:
- DEBOUNCE_CYCLES, 1000000: number of consecutive stable samples required before a level change is accepted. The default is 20 ms at 50 MHz. Legal range is 2 to 2^24.
- ACTIVE_LOW, 1: 1 means a raw key reads 0 when pressed; 0 means it reads 1 when pressed.
- STRETCH_CYCLES, 4: output pulse width when MUJICA_KEY_STRETCH_EN is defined. Legal range is 1 to 255.

Ports:
- sys_clk  in  1  50 MHz system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- key_power_raw  in  1  asynchronous raw power button.
- key_save_raw  in  1  asynchronous raw save button.
- key_fetch_raw  in  1  asynchronous raw fetch button.
- key_finish_raw  in  1  asynchronous raw finish button.
- start_power  out  1  power press pulse.
- start_save  out  1  save press pulse.
- start_fetch  out  1  fetch press pulse.
- finish_fetch  out  1  finish press pulse; not arbitrated against the start pulses.
- key_conflict  out  1  one-cycle flag: two or more start presses were accepted in the same cycle.
- key_level  out  4  debounced pressed levels, packed {finish, fetch, save, power}; 1 means pressed.

Behaviour:
- Reset: all outputs are 0.
  - Synchroniser flops reset to the released level, which is 1 when ACTIVE_LOW=1.
  - Debounce counters reset to 0.
  - All channel state machines reset to RELEASED.
- Synchroniser: each raw input passes through two flops, s1 then s2. The value p is s2 after polarity normalisation, so p=1 means pressed.
- Per-channel state machine, counter width 24 bits:
  - RELEASED: when p=1, go to PRESS_WAIT with cnt=1.
  - PRESS_WAIT:
    - p=0: return to RELEASED and clear cnt.
    - p=1 and cnt==DEBOUNCE_CYCLES-1: go to PRESSED, clear cnt, and assert the internal edge strobe for one cycle.
    - Otherwise: cnt+1.
  - PRESSED: when p=0, go to RELEASE_WAIT with cnt=1.
  - RELEASE_WAIT:
    - p=1: return to PRESSED and clear cnt.
    - p=0 and cnt==DEBOUNCE_CYCLES-1: go to RELEASED and clear cnt.
    - Otherwise: cnt+1.
  - The counter never wraps; it is cleared on every state change.
  - key_level bit is 1 in PRESSED and RELEASE_WAIT.
- Latency: with a raw input stable from the cycle of its edge, the output pulse is high during the cycle after exactly DEBOUNCE_CYCLES+3 rising edges of sys_clk.
  - This is 2 edges for the synchroniser, DEBOUNCE_CYCLES edges for the debounce, and 1 edge for the output register.
- Any glitch shorter than DEBOUNCE_CYCLES samples produces no pulse and no key_level change.
- A held key produces exactly one pulse. No further pulse is issued until a debounced release is followed by a debounced press.
- Arbitration (registered):
  - start_power = edge_power.
  - start_save = edge_save & ~edge_power.
  - start_fetch = edge_fetch & ~edge_save & ~edge_power.
  - key_conflict = 1 when at least two of the three start edges are set in the same cycle. It is registered in the same cycle as the winning pulse.
- finish_fetch = edge_finish. It may coincide with any start pulse.
- Reset mid-debounce: the state machine goes back to RELEASED and cnt clears. A key held through reset release produces one pulse DEBOUNCE_CYCLES+3 edges after rst_n deasserts.

Optional Feature:
- Macro MUJICA_KEY_STRETCH_EN.
- When defined:
  - Each output pulse (start_*, finish_fetch) is held high for STRETCH_CYCLES consecutive cycles using an 8-bit down-counter per output.
  - A new edge arriving on the same output during a stretch restarts the count.
  - key_conflict is not stretched.
- When undefined: every pulse is exactly one cycle, and the stretch counters are not generated.

Test Plan:
- Setup: DEBOUNCE_CYCLES=8, ACTIVE_LOW=1.
- Clean press: key_save_raw 1->0 and held for 30 cycles.
  - start_save is high for exactly 1 cycle, 11 edges after the fall.
  - key_level=4'b0010 from that point on.
  - No other outputs change.
- Glitch rejection: key_power_raw low for 5 cycles, then high; repeated 10 times.
  - start_power stays 0 and key_level stays 0.
- Bounce: key_fetch_raw toggles every 3 cycles for 40 cycles, then is held low.
  - Exactly one start_fetch pulse, 11 edges after the final fall.
  - Release with bounce, then a clean re-press: one more pulse.
- Simultaneous press: key_power_raw, key_save_raw and key_fetch_raw fall on the same cycle.
  - Only start_power pulses.
  - key_conflict is high for 1 cycle, coincident with that pulse.
  - start_save and start_fetch stay 0.
- Finish independence: key_finish_raw and key_save_raw fall together.
  - finish_fetch and start_save pulse in the same cycle.
  - key_conflict stays 0.
- Reset mid-operation: key_power_raw held low, rst_n pulsed low at debounce cycle 5.
  - Outputs are 0 during reset.
  - start_power pulses 11 edges after rst_n rises.
  - With MUJICA_KEY_STRETCH_EN and STRETCH_CYCLES=4, that pulse is 4 cycles wide.

Source files
------------

// File: rtl/mujica_key_conditioner.sv
// ---------------------------------------------------------------------------
// mujica_key_conditioner
//
// Upstream stage of the Mujica top control FSM. It takes the four raw
// mechanical pushbuttons (power, save, fetch, finish) and turns them into
// clean one-cycle command pulses in the sys_clk domain.
//
// Each button gets its own processing chain:
//   - a two-flop synchroniser
//   - a four-state debounce machine with a 24-bit stability counter
//   - a press-edge strobe
//
// The three start commands are then arbitrated with a fixed priority:
// power beats save, and save beats fetch.
//
// Optional build macro:
//   MUJICA_KEY_STRETCH_EN - when defined, every command pulse (start_*,
//                           finish_fetch) is held high for STRETCH_CYCLES
//                           cycles. key_conflict is never stretched.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable samples needed to accept a level
//                    change (2 .. 2^24)
//   ACTIVE_LOW       1: a raw key reads 0 when pressed; 0: it reads 1
//   STRETCH_CYCLES   pulse width when stretching is enabled (1 .. 255)
//
// Ports:
//   sys_clk         system clock (50 MHz)
//   rst_n           asynchronous active-low reset
//   key_*_raw       asynchronous raw button inputs
//   start_power     power press pulse (highest priority)
//   start_save      save press pulse (suppressed by a coincident power)
//   start_fetch     fetch press pulse (suppressed by coincident power/save)
//   finish_fetch    finish press pulse, independent of the start pulses
//   key_conflict    one cycle: two or more start presses were accepted together
//   key_level       debounced pressed levels {finish, fetch, save, power}
// ---------------------------------------------------------------------------
module mujica_key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned STRETCH_CYCLES  = 4
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       key_power_raw,
  input  logic       key_save_raw,
  input  logic       key_fetch_raw,
  input  logic       key_finish_raw,
  output logic       start_power,
  output logic       start_save,
  output logic       start_fetch,
  output logic       finish_fetch,
  output logic       key_conflict,
  output logic [3:0] key_level
);

  localparam int NUM_KEYS = 4;
  localparam int CNT_W    = 24;

  // Channel indices inside the packed vectors:
  // 0 = power, 1 = save, 2 = fetch, 3 = finish.
  localparam int KEY_POWER  = 0;
  localparam int KEY_SAVE   = 1;
  localparam int KEY_FETCH  = 2;
  localparam int KEY_FINISH = 3;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Raw level that means "released" for every key.
  localparam logic [NUM_KEYS-1:0] RELEASED_LEVELS = {NUM_KEYS{ACTIVE_LOW}};

  // An out-of-range configuration would give undefined debounce timing or
  // pulse widths. Such a build keeps the command outputs quiet instead of
  // issuing malformed pulses.
  localparam bit CFG_OK = (DEBOUNCE_CYCLES >= 32'd2)
                       && (DEBOUNCE_CYCLES <= 32'd16777216)
                       && (STRETCH_CYCLES  >= 32'd1)
                       && (STRETCH_CYCLES  <= 32'd255);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_RELEASE_WAIT
  } key_state_e;

  logic [NUM_KEYS-1:0] rawKeys;
  logic [NUM_KEYS-1:0] syncStage1_q;
  logic [NUM_KEYS-1:0] syncStage2_q;
  logic [NUM_KEYS-1:0] keyPressed;
  logic [NUM_KEYS-1:0] edgeAll;
  logic [NUM_KEYS-1:0] levelAll;

  assign rawKeys = {key_finish_raw, key_fetch_raw, key_save_raw, key_power_raw};

  // Two-flop synchroniser for the asynchronous button inputs.
  // The flops reset to the released level so that no press is seen while
  // coming out of reset.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      syncStage1_q <= RELEASED_LEVELS;
      syncStage2_q <= RELEASED_LEVELS;
    end else begin
      syncStage1_q <= rawKeys;
      syncStage2_q <= syncStage1_q;
    end
  end

  // Polarity normalisation: 1 means pressed regardless of ACTIVE_LOW.
  assign keyPressed = syncStage2_q ^ RELEASED_LEVELS;

  // Per-channel debounce machine. A level change is accepted only after
  // DEBOUNCE_CYCLES consecutive identical samples. Entering a wait state
  // loads the counter with 1 because that sample already counts. The counter
  // is cleared on every state change, so it never reaches DEBOUNCE_CYCLES
  // and cannot wrap.
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
    key_state_e       state_q;
    key_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             edgeStrobe_q;
    logic             edgeStrobe_d;

    // State, counter and edge-strobe registers for this channel.
    always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q      <= ST_RELEASED;
        cnt_q        <= '0;
        edgeStrobe_q <= 1'b0;
      end else begin
        state_q      <= state_d;
        cnt_q        <= cnt_d;
        edgeStrobe_q <= edgeStrobe_d;
      end
    end

    // Next-state logic. The edge strobe fires only on the
    // PRESS_WAIT -> PRESSED transition. A held key therefore yields a single
    // strobe until a debounced release has happened.
    always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      edgeStrobe_d = 1'b0;
      case (state_q)
        ST_RELEASED: begin
          if (keyPressed[k]) begin
            state_d = ST_PRESS_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
        ST_PRESS_WAIT: begin
          if (!keyPressed[k]) begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d      = ST_PRESSED;
            cnt_d        = '0;
            edgeStrobe_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!keyPressed[k]) begin
            state_d = ST_RELEASE_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
        ST_RELEASE_WAIT: begin
          if (keyPressed[k]) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end
      endcase
    end

    assign edgeAll[k]  = edgeStrobe_q;
    // The debounced level stays high while a release is still being
    // confirmed.
    assign levelAll[k] = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);
  end

  // Fixed-priority arbitration of the start commands. The finish channel
  // passes straight through because it may coincide with any start.
  logic [NUM_KEYS-1:0] winner;
  logic [NUM_KEYS-1:0] winnerGated;
  logic                conflictNow;

  assign winner[KEY_POWER]  = edgeAll[KEY_POWER];
  assign winner[KEY_SAVE]   = edgeAll[KEY_SAVE] & ~edgeAll[KEY_POWER];
  assign winner[KEY_FETCH]  = edgeAll[KEY_FETCH] & ~edgeAll[KEY_SAVE]
                            & ~edgeAll[KEY_POWER];
  assign winner[KEY_FINISH] = edgeAll[KEY_FINISH];

  assign conflictNow = (edgeAll[KEY_POWER] & edgeAll[KEY_SAVE])
                     | (edgeAll[KEY_POWER] & edgeAll[KEY_FETCH])
                     | (edgeAll[KEY_SAVE]  & edgeAll[KEY_FETCH]);

  assign winnerGated = CFG_OK ? winner : '0;

  // The conflict flag is registered alongside the winning pulse and is
  // always exactly one cycle wide.
  logic conflict_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflictNow & CFG_OK;
    end
  end

  logic [NUM_KEYS-1:0] pulseOut;

`ifdef MUJICA_KEY_STRETCH_EN
  localparam logic [7:0] STRETCH_LOAD = 8'(STRETCH_CYCLES);

  // Per-output stretch down-counter. A new winning edge reloads the count,
  // so an edge that arrives during a stretch extends the pulse instead of
  // being lost.
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_stretch
    logic [7:0] stretchCnt_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
        stretchCnt_q <= 8'd0;
      end else if (winnerGated[k]) begin
        stretchCnt_q <= STRETCH_LOAD;
      end else if (stretchCnt_q != 8'd0) begin
        stretchCnt_q <= stretchCnt_q - 8'd1;
      end
    end

    assign pulseOut[k] = (stretchCnt_q != 8'd0);
  end
`else
  logic [NUM_KEYS-1:0] pulse_q;

  // Output register: each accepted press becomes a single-cycle pulse.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q <= '0;
    end else begin
      pulse_q <= winnerGated;
    end
  end

  assign pulseOut = pulse_q;
`endif

  assign start_power  = pulseOut[KEY_POWER];
  assign start_save   = pulseOut[KEY_SAVE];
  assign start_fetch  = pulseOut[KEY_FETCH];
  assign finish_fetch = pulseOut[KEY_FINISH];
  assign key_conflict = conflict_q;
  assign key_level    = levelAll;

endmodule

// File: tb/tb_mujica_key_conditioner.sv
// ---------------------------------------------------------------------------
// tb_mujica_key_conditioner
//
// Self-checking bench for mujica_key_conditioner with DEBOUNCE_CYCLES=8 and
// ACTIVE_LOW=1.
//
// Whenever the stimulus presses a key, it pushes the pulse it expects (the
// cycle number and the output vector) into a scoreboard queue. A monitor
// samples the outputs on every falling edge and compares them against the
// head of that queue.
//
// Observed output vector: {key_conflict, finish_fetch, start_fetch,
// start_save, start_power}.
// ---------------------------------------------------------------------------
module tb_mujica_key_conditioner;

  localparam int DEB = 8;
  // A press is visible DEB+3 rising edges after the raw input changes.
  localparam int LAT = DEB + 3;
`ifdef MUJICA_KEY_STRETCH_EN
  localparam int PULSE_W = 4;
`else
  localparam int PULSE_W = 1;
`endif

  logic       sys_clk;
  logic       rst_n;
  logic       key_power_raw;
  logic       key_save_raw;
  logic       key_fetch_raw;
  logic       key_finish_raw;
  logic       start_power;
  logic       start_save;
  logic       start_fetch;
  logic       finish_fetch;
  logic       key_conflict;
  logic [3:0] key_level;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [4:0] vec;
  } expect_t;

  expect_t    expQ[$];
  expect_t    headExp;
  logic [4:0] obsVec;

  mujica_key_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .ACTIVE_LOW     (1'b1),
    .STRETCH_CYCLES (4)
  ) dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .key_power_raw (key_power_raw),
    .key_save_raw  (key_save_raw),
    .key_fetch_raw (key_fetch_raw),
    .key_finish_raw(key_finish_raw),
    .start_power   (start_power),
    .start_save    (start_save),
    .start_fetch   (start_fetch),
    .finish_fetch  (finish_fetch),
    .key_conflict  (key_conflict),
    .key_level     (key_level)
  );

  assign obsVec = {key_conflict, finish_fetch, start_fetch, start_save, start_power};

  // 100 MHz bench clock; period 10 time units.
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Rising-edge counter used to timestamp the expected pulses.
  always @(posedge sys_clk) cyc++;

  // Scoreboard monitor: on every falling edge it retires entries whose cycle
  // has passed unseen, then matches the current output vector against the
  // entry due this cycle. Any pulse with no entry due is unexpected.
  always @(negedge sys_clk) begin
    while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("[TB] FAIL pulse_missed cycle=%0d got none, expected vec=%b", expQ[0].cyc, expQ[0].vec);
      void'(expQ.pop_front());
    end
    if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
      headExp = expQ.pop_front();
      checks++;
      if (obsVec !== headExp.vec) begin
        failures++;
        $display("[TB] FAIL pulse_vector cycle=%0d got=%b expected=%b", cyc, obsVec, headExp.vec);
      end
    end else if (obsVec !== 5'b00000) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_pulse cycle=%0d got=%b expected=00000", cyc, obsVec);
    end
  end

  // Queue the expected pulse; when stretching is enabled, the pulse occupies
  // PULSE_W consecutive cycles and key_conflict appears only in the first.
  task automatic expectPulse(input int atCycle, input logic [4:0] vec);
    expect_t e;
    for (int i = 0; i < PULSE_W; i++) begin
      e.cyc = atCycle + i;
      e.vec = (i == 0) ? vec : (vec & 5'b01111);
      expQ.push_back(e);
    end
  endtask

  // Drive the raw keys from a pressed mask {finish, fetch, save, power};
  // the keys are active-low.
  task automatic applyStimulus(input logic [3:0] pressMask);
    key_power_raw  = ~pressMask[0];
    key_save_raw   = ~pressMask[1];
    key_fetch_raw  = ~pressMask[2];
    key_finish_raw = ~pressMask[3];
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Advance n rising edges and land just after the last one.
  task automatic waitCycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Watchdog guarding against a stalled run.
  initial begin
    #100000;
    checks++;
    failures++;
    $display("[TB] FAIL watchdog timeout cycle=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(4'b0000);
    waitCycles(3);
    checkOutput("reset_outputs", {23'd0, obsVec, key_level}, 32'd0);
    rst_n = 1'b1;
    waitCycles(5);
    checkOutput("idle_after_reset", {23'd0, obsVec, key_level}, 32'd0);

    // Clean press of save.
    applyStimulus(4'b0010);
    expectPulse(cyc + LAT, 5'b00010);
    waitCycles(LAT + 1);
    checkOutput("clean_level", 32'(key_level), 32'h2);
    waitCycles(17);
    checkOutput("clean_level_held", 32'(key_level), 32'h2);
    applyStimulus(4'b0000);
    waitCycles(14);
    checkOutput("clean_release", 32'(key_level), 32'h0);

    // Glitch rejection: 5-cycle power presses, repeated ten times.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b0001);
      waitCycles(5);
      applyStimulus(4'b0000);
      waitCycles(5);
    end
    waitCycles(12);
    checkOutput("glitch_level", 32'(key_level), 32'h0);

    // Fetch bouncing every 3 cycles, then a final clean fall.
    for (int i = 0; i < 14; i++) begin
      applyStimulus((i % 2 == 0) ? 4'b0100 : 4'b0000);
      waitCycles(3);
    end
    applyStimulus(4'b0100);
    expectPulse(cyc + LAT, 5'b00100);
    waitCycles(20);
    checkOutput("bounce_level", 32'(key_level), 32'h4);
    for (int i = 0; i < 14; i++) begin
      applyStimulus((i % 2 == 0) ? 4'b0000 : 4'b0100);
      waitCycles(3);
    end
    applyStimulus(4'b0000);
    waitCycles(14);
    checkOutput("bounce_release", 32'(key_level), 32'h0);
    applyStimulus(4'b0100);
    expectPulse(cyc + LAT, 5'b00100);
    waitCycles(20);
    checkOutput("repress_level", 32'(key_level), 32'h4);
    applyStimulus(4'b0000);
    waitCycles(14);

    // Simultaneous power, save and fetch: only power wins, conflict flagged.
    applyStimulus(4'b0111);
    expectPulse(cyc + LAT, 5'b10001);
    waitCycles(20);
    checkOutput("simul_level", 32'(key_level), 32'h7);
    applyStimulus(4'b0000);
    waitCycles(14);
    checkOutput("simul_release", 32'(key_level), 32'h0);

    // Finish together with save: both pulse, no conflict.
    applyStimulus(4'b1010);
    expectPulse(cyc + LAT, 5'b01010);
    waitCycles(20);
    checkOutput("finish_level", 32'(key_level), 32'hA);
    applyStimulus(4'b0000);
    waitCycles(14);
    checkOutput("finish_release", 32'(key_level), 32'h0);

    // Reset in the middle of a power debounce, with the key held throughout.
    applyStimulus(4'b0001);
    waitCycles(7);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async_outputs", {23'd0, obsVec, key_level}, 32'd0);
    waitCycles(3);
    checkOutput("reset_hold_outputs", {23'd0, obsVec, key_level}, 32'd0);
    rst_n = 1'b1;
    expectPulse(cyc + LAT, 5'b00001);
    waitCycles(20);
    checkOutput("post_reset_level", 32'(key_level), 32'h1);
    applyStimulus(4'b0000);
    waitCycles(14);

    waitCycles(10);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
